// File: rtl/memory_pkg.sv
// Shared types for the pipelined dual-port memory.
//   rdw_mode_e    : read-during-write policy selector
//   clear_state_e : zero-fill controller states
package memory_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    READ_FIRST  = 1'b0,
    WRITE_FIRST = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clear_state_e;

endpackage

// File: rtl/pipelined_dual_port_memory_if.sv
// Request/response bus for one port of the dual-port memory.
//   master : drives req_valid, address, rd_en, wr_en (byte mask), wr_data
//   slave  : drives req_ready, rsp_valid, rsp_data
interface pipelined_dual_port_memory_if #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned WORD_BYTES = 4
);

  localparam int unsigned DATA_W = 8 * WORD_BYTES;

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     address;
  logic                  rd_en;
  logic [WORD_BYTES-1:0] wr_en;
  logic [DATA_W-1:0]     wr_data;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_data;

  modport master (
    output req_valid, address, rd_en, wr_en, wr_data,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, address, rd_en, wr_en, wr_data,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/read_pipeline.sv
// Fixed-latency delay line for read responses (valid + data).
//   clk, reset_n        : clock, async active-low reset
//   in_valid, in_data   : read word captured at request acceptance
//   out_valid, out_data : response LATENCY cycles later; data holds while idle
module read_pipeline #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [LATENCY-1:0] vld_q;
  logic [DATA_W-1:0]  dat_q [LATENCY];

  // Data registers only load behind a valid bit, so the last stage holds
  // its value whenever no response is being presented.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) dat_q[0] <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_data  = dat_q[LATENCY-1];

endmodule

// File: rtl/pipelined_dual_port_memory.sv
// True dual-port byte-maskable memory with pipelined reads and a zero-fill engine.
//   clk, reset_n           : single clock, async active-low reset (array not reset)
//   clear_req              : start zero-fill (sampled only when idle)
//   clear_busy, clear_done : fill in progress / one-cycle completion pulse
//   port_a, port_b         : request/response buses; port A wins byte collisions
module pipelined_dual_port_memory
  import memory_pkg::*;
#(
  parameter string       INIT_FILE      = "",
  parameter int unsigned CAPACITY_BYTES = 1024,
  parameter int unsigned WORD_BYTES     = 4,
  parameter int unsigned READ_LATENCY   = 2,
  parameter rdw_mode_e   RDW_MODE       = READ_FIRST
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear_req,
  output logic                          clear_busy,
  output logic                          clear_done,
  pipelined_dual_port_memory_if.slave   port_a,
  pipelined_dual_port_memory_if.slave   port_b
);

  localparam int unsigned ADDR_W     = $clog2(CAPACITY_BYTES);
  localparam int unsigned OFF_W      = $clog2(WORD_BYTES);
  localparam int unsigned IDX_W      = ADDR_W - OFF_W;
  localparam int unsigned WORD_COUNT = CAPACITY_BYTES / WORD_BYTES;
  localparam int unsigned DATA_W     = BYTE_W * WORD_BYTES;

  logic [DATA_W-1:0] mem [WORD_COUNT];

  // Power-up image for the array; it is never touched by reset.
  initial begin
    for (int i = 0; i < WORD_COUNT; i++) mem[i] = '0;
  end

  // Zero-fill controller
  clear_state_e     state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             busy_d, done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clear_busy <= busy_d;
      clear_done <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == IDX_W'(WORD_COUNT - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLEAR);
  end

  // Request acceptance: both ports stall for the whole fill
  logic             acc_a, acc_b, rd_a, rd_b;
  logic [IDX_W-1:0] idx_a, idx_b;

  assign port_a.req_ready = ~clear_busy;
  assign port_b.req_ready = ~clear_busy;
  assign acc_a = port_a.req_valid & ~clear_busy;
  assign acc_b = port_b.req_valid & ~clear_busy;
  assign rd_a  = acc_a & port_a.rd_en;
  assign rd_b  = acc_b & port_b.rd_en;
  assign idx_a = port_a.address[ADDR_W-1:OFF_W];
  assign idx_b = port_b.address[ADDR_W-1:OFF_W];

  if (OFF_W > 0) begin : g_byte_offset
    logic unused_offset;
    assign unused_offset = ^{port_a.address[OFF_W-1:0], port_b.address[OFF_W-1:0]};
  end

  // Array write: B bytes first so A overrides any byte both ports enable
  always_ff @(posedge clk) begin
    if (clear_busy) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int b = 0; b < WORD_BYTES; b++)
        if (acc_b && port_b.wr_en[b]) mem[idx_b][BYTE_W*b +: BYTE_W] <= port_b.wr_data[BYTE_W*b +: BYTE_W];
      for (int b = 0; b < WORD_BYTES; b++)
        if (acc_a && port_a.wr_en[b]) mem[idx_a][BYTE_W*b +: BYTE_W] <= port_a.wr_data[BYTE_W*b +: BYTE_W];
    end
  end

  // Read word; in WRITE_FIRST mode same-cycle writes are forwarded with A priority
  logic [DATA_W-1:0] rd_word_a, rd_word_b;

  always_comb begin
    rd_word_a = mem[idx_a];
    rd_word_b = mem[idx_b];
    if (RDW_MODE == WRITE_FIRST) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (acc_b && port_b.wr_en[b] && idx_b == idx_a)
          rd_word_a[BYTE_W*b +: BYTE_W] = port_b.wr_data[BYTE_W*b +: BYTE_W];
        if (acc_b && port_b.wr_en[b])
          rd_word_b[BYTE_W*b +: BYTE_W] = port_b.wr_data[BYTE_W*b +: BYTE_W];
      end
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (acc_a && port_a.wr_en[b])
          rd_word_a[BYTE_W*b +: BYTE_W] = port_a.wr_data[BYTE_W*b +: BYTE_W];
        if (acc_a && port_a.wr_en[b] && idx_a == idx_b)
          rd_word_b[BYTE_W*b +: BYTE_W] = port_a.wr_data[BYTE_W*b +: BYTE_W];
      end
    end
  end

  read_pipeline #(
    .LATENCY (READ_LATENCY),
    .DATA_W  (DATA_W)
  ) u_read_pipe_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (rd_a),
    .in_data   (rd_word_a),
    .out_valid (port_a.rsp_valid),
    .out_data  (port_a.rsp_data)
  );

  read_pipeline #(
    .LATENCY (READ_LATENCY),
    .DATA_W  (DATA_W)
  ) u_read_pipe_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (rd_b),
    .in_data   (rd_word_b),
    .out_valid (port_b.rsp_valid),
    .out_data  (port_b.rsp_data)
  );

endmodule

// File: tb/tb_pipelined_dual_port_memory.sv
// Scoreboard bench: two memories (READ_FIRST/latency 3 and WRITE_FIRST/latency 1)
// driven with identical stimulus and checked against a byte-array reference.
module tb_pipelined_dual_port_memory;
  import memory_pkg::*;

  localparam int unsigned CAP    = 64;
  localparam int unsigned WB     = 4;
  localparam int unsigned AW     = 6;
  localparam int unsigned DW     = 32;
  localparam int unsigned WORDS  = CAP / WB;
  localparam int unsigned LAT_RF = 3;
  localparam int unsigned LAT_WF = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clear_req = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          a_valid, b_valid, a_rd, b_rd;
  logic [AW-1:0] a_addr, b_addr;
  logic [WB-1:0] a_wr, b_wr;
  logic [DW-1:0] a_data, b_data;
  logic          rf_busy, rf_done, wf_busy, wf_done;

  pipelined_dual_port_memory_if #(.ADDR_W(AW), .WORD_BYTES(WB)) rf_a ();
  pipelined_dual_port_memory_if #(.ADDR_W(AW), .WORD_BYTES(WB)) rf_b ();
  pipelined_dual_port_memory_if #(.ADDR_W(AW), .WORD_BYTES(WB)) wf_a ();
  pipelined_dual_port_memory_if #(.ADDR_W(AW), .WORD_BYTES(WB)) wf_b ();

  assign rf_a.req_valid = a_valid; assign rf_a.address = a_addr; assign rf_a.rd_en = a_rd;
  assign rf_a.wr_en = a_wr;        assign rf_a.wr_data = a_data;
  assign wf_a.req_valid = a_valid; assign wf_a.address = a_addr; assign wf_a.rd_en = a_rd;
  assign wf_a.wr_en = a_wr;        assign wf_a.wr_data = a_data;
  assign rf_b.req_valid = b_valid; assign rf_b.address = b_addr; assign rf_b.rd_en = b_rd;
  assign rf_b.wr_en = b_wr;        assign rf_b.wr_data = b_data;
  assign wf_b.req_valid = b_valid; assign wf_b.address = b_addr; assign wf_b.rd_en = b_rd;
  assign wf_b.wr_en = b_wr;        assign wf_b.wr_data = b_data;

  pipelined_dual_port_memory #(
    .INIT_FILE(""), .CAPACITY_BYTES(CAP), .WORD_BYTES(WB),
    .READ_LATENCY(LAT_RF), .RDW_MODE(READ_FIRST)
  ) dut_rf (
    .clk(clk), .reset_n(rst_n), .clear_req(clear_req),
    .clear_busy(rf_busy), .clear_done(rf_done), .port_a(rf_a), .port_b(rf_b)
  );

  pipelined_dual_port_memory #(
    .INIT_FILE(""), .CAPACITY_BYTES(CAP), .WORD_BYTES(WB),
    .READ_LATENCY(LAT_WF), .RDW_MODE(WRITE_FIRST)
  ) dut_wf (
    .clk(clk), .reset_n(rst_n), .clear_req(clear_req),
    .clear_busy(wf_busy), .clear_done(wf_done), .port_a(wf_a), .port_b(wf_b)
  );

  typedef struct {
    int unsigned   cyc;
    logic [DW-1:0] data;
  } exp_t;

  exp_t        sb [4][$];  // 0: rf A, 1: rf B, 2: wf A, 3: wf B
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mem_b [CAP];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_at(input int unsigned w);
    logic [DW-1:0] r;
    for (int k = 0; k < WB; k++) r[8*k +: 8] = mem_b[w*WB + k];
    return r;
  endfunction

  // Response monitor: pop and compare whenever a DUT presents a response
  logic          mv [4];
  logic [DW-1:0] md [4];
  logic [DW-1:0] last [4] = '{default: '0};
  exp_t          e;

  always @(negedge clk) begin
    mv[0] = rf_a.rsp_valid; md[0] = rf_a.rsp_data;
    mv[1] = rf_b.rsp_valid; md[1] = rf_b.rsp_data;
    mv[2] = wf_a.rsp_valid; md[2] = wf_a.rsp_data;
    mv[3] = wf_b.rsp_valid; md[3] = wf_b.rsp_data;
    for (int p = 0; p < 4; p++) begin
      if (!rst_n) begin
        check($sformatf("reset_rsp_valid[%0d]", p), 32'(mv[p]), 32'd0);
        check($sformatf("reset_rsp_data[%0d]", p), md[p], 32'd0);
        last[p] = '0;
      end else if (mv[p]) begin
        if (sb[p].size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp[%0d] at cycle %0d: got data %h expected no response", p, cyc, md[p]);
        end else begin
          e = sb[p].pop_front();
          check($sformatf("rsp_cycle[%0d]", p), cyc, e.cyc);
          check($sformatf("rsp_data[%0d]", p), md[p], e.data);
        end
        last[p] = md[p];
      end else begin
        check($sformatf("rsp_hold[%0d]", p), md[p], last[p]);
        if (sb[p].size() != 0 && sb[p][0].cyc <= cyc) begin
          checks++; errors++;
          $display("FAIL missing_rsp[%0d] at cycle %0d: got no response expected data %h due cycle %0d",
                   p, cyc, sb[p][0].data, sb[p][0].cyc);
          void'(sb[p].pop_front());
        end
      end
    end
  end

  task automatic drive_idle();
    a_valid = 1'b0; b_valid = 1'b0; a_rd = 1'b0; b_rd = 1'b0;
    a_wr = '0; b_wr = '0;
  endtask

  // One request cycle on both ports; reference applies B then A so A wins shared bytes
  task automatic req(input logic av, input logic [AW-1:0] aa, input logic ard,
                     input logic [WB-1:0] awr, input logic [DW-1:0] ad,
                     input logic bv, input logic [AW-1:0] ba, input logic brd,
                     input logic [WB-1:0] bwr, input logic [DW-1:0] bd);
    int unsigned   wa, wb;
    logic [DW-1:0] pre_a, pre_b;
    a_valid = av; a_addr = aa; a_rd = ard; a_wr = awr; a_data = ad;
    b_valid = bv; b_addr = ba; b_rd = brd; b_wr = bwr; b_data = bd;
    check("req_ready", 32'({rf_a.req_ready, rf_b.req_ready, wf_a.req_ready, wf_b.req_ready}), 32'hF);
    wa = int'(aa) / WB;
    wb = int'(ba) / WB;
    pre_a = word_at(wa);
    pre_b = word_at(wb);
    if (bv) for (int k = 0; k < WB; k++) if (bwr[k]) mem_b[wb*WB + k] = bd[8*k +: 8];
    if (av) for (int k = 0; k < WB; k++) if (awr[k]) mem_b[wa*WB + k] = ad[8*k +: 8];
    if (av && ard) begin
      sb[0].push_back('{cyc: cyc + LAT_RF, data: pre_a});
      sb[2].push_back('{cyc: cyc + LAT_WF, data: word_at(wa)});
    end
    if (bv && brd) begin
      sb[1].push_back('{cyc: cyc + LAT_RF, data: pre_b});
      sb[3].push_back('{cyc: cyc + LAT_WF, data: word_at(wb)});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive_idle();
    repeat (n) @(negedge clk);
  endtask

  task automatic read_all();
    for (int w = 0; w < WORDS / 2; w++)
      req(1'b1, AW'(w*WB + $urandom_range(0, WB-1)), 1'b1, '0, '0,
          1'b1, AW'((w + WORDS/2)*WB + $urandom_range(0, WB-1)), 1'b1, '0, '0);
    idle(LAT_RF + 2);
  endtask

  // Zero-fill with reads issued alongside the request; optionally reset at word 5
  task automatic do_clear(input bit abort);
    int unsigned wa, wb;
    wa = $urandom_range(0, WORDS-1);
    wb = $urandom_range(0, WORDS-1);
    clear_req = 1'b1;
    req(1'b1, AW'(wa*WB), 1'b1, '0, '0, 1'b1, AW'(wb*WB), 1'b1, '0, '0);
    a_valid = 1'b1; a_rd = 1'b1; a_wr = 4'hF; a_data = $urandom;
    b_valid = 1'b1; b_rd = 1'b1; b_wr = 4'hF; b_data = $urandom;
    for (int i = 0; i < int'(WORDS); i++) begin
      if (i == 2) clear_req = 1'b0;
      if (abort && i == 5) begin
        #2 rst_n = 1'b0;
        drive_idle();
        #1;
        check("abort_busy", 32'({rf_busy, wf_busy}), 32'd0);
        check("abort_done", 32'({rf_done, wf_done}), 32'd0);
        for (int w = 0; w < 5; w++) for (int k = 0; k < WB; k++) mem_b[w*WB + k] = 8'h00;
        repeat (2) begin
          @(negedge clk);
          check("abort_done_hold", 32'({rf_done, wf_done}), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", 32'({rf_a.req_ready, rf_b.req_ready, wf_a.req_ready, wf_b.req_ready}), 32'hF);
        check("done_after_reset", 32'({rf_done, wf_done}), 32'd0);
        @(negedge clk);
        return;
      end
      check("clear_busy", 32'({rf_busy, wf_busy}), 32'h3);
      check("clear_ready", 32'({rf_a.req_ready, rf_b.req_ready, wf_a.req_ready, wf_b.req_ready}), 32'h0);
      check("clear_done_early", 32'({rf_done, wf_done}), 32'd0);
      @(negedge clk);
    end
    drive_idle();
    check("clear_end_busy", 32'({rf_busy, wf_busy}), 32'd0);
    check("clear_done_pulse", 32'({rf_done, wf_done}), 32'h3);
    check("clear_end_ready", 32'({rf_a.req_ready, rf_b.req_ready, wf_a.req_ready, wf_b.req_ready}), 32'hF);
    for (int j = 0; j < int'(CAP); j++) mem_b[j] = 8'h00;
    @(negedge clk);
    check("clear_done_single", 32'({rf_done, wf_done}), 32'd0);
  endtask

  initial begin
    drive_idle();
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    for (int j = 0; j < int'(CAP); j++) mem_b[j] = 8'h00;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'({rf_busy, wf_busy}), 32'd0);
    check("reset_done", 32'({rf_done, wf_done}), 32'd0);
    rst_n = 1'b1;
    #1 check("ready_first_cycle", 32'({rf_a.req_ready, rf_b.req_ready, wf_a.req_ready, wf_b.req_ready}), 32'hF);
    @(negedge clk);

    // Write then read with ignored low address bits
    req(1'b1, 6'h10, 1'b0, 4'hF, 32'hDEADBEEF, 1'b0, 6'h00, 1'b0, '0, '0);
    req(1'b0, 6'h00, 1'b0, '0, '0, 1'b1, 6'h13, 1'b1, '0, '0);
    idle(4);
    // Same-word dual write collision, then readback
    req(1'b1, 6'h20, 1'b0, 4'h3, 32'h11111111, 1'b1, 6'h20, 1'b0, 4'h6, 32'h22222222);
    req(1'b1, 6'h20, 1'b1, '0, '0, 1'b1, 6'h22, 1'b1, '0, '0);
    idle(4);
    // Read-during-write, opposite port and same port
    req(1'b1, 6'h30, 1'b0, 4'hF, 32'hAAAAAAAA, 1'b0, 6'h00, 1'b0, '0, '0);
    req(1'b1, 6'h30, 1'b0, 4'hF, 32'h55555555, 1'b1, 6'h30, 1'b1, '0, '0);
    req(1'b1, 6'h34, 1'b1, '0, '0, 1'b1, 6'h35, 1'b0, 4'h9, 32'hC3C3C3C3);
    req(1'b1, 6'h38, 1'b1, 4'h5, 32'h12345678, 1'b1, 6'h38, 1'b1, 4'hC, 32'h9ABCDEF0);
    req(1'b1, 6'h3C, 1'b0, 4'h0, 32'hFFFFFFFF, 1'b1, 6'h3C, 1'b1, 4'h0, 32'hFFFFFFFF);
    idle(5);

    // Back-to-back reads on both ports
    for (int i = 0; i < 32; i++)
      req(1'b1, AW'($urandom_range(0, CAP-1)), 1'b1, '0, '0,
          1'b1, AW'($urandom_range(0, CAP-1)), 1'b1, '0, '0);
    idle(5);

    // Randomised mixed traffic
    for (int i = 0; i < 300; i++)
      req(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, CAP-1)), 1'($urandom),
          ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom), $urandom,
          1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, CAP-1)), 1'($urandom),
          ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom), $urandom);
    idle(5);

    // Full zero-fill, then read every word
    do_clear(1'b0);
    read_all();

    // Prefill, abort the fill at word 5 with reset, then read every word
    for (int w = 0; w < int'(WORDS); w++)
      req(1'b1, AW'(w*WB), 1'b0, 4'hF, $urandom | 32'h01010101, 1'b0, '0, 1'b0, '0, '0);
    idle(2);
    do_clear(1'b1);
    read_all();

    idle(5);
    for (int p = 0; p < 4; p++) check($sformatf("sb_drained[%0d]", p), 32'(sb[p].size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipelined_dual_port_memory.md
PIPELINED_DUAL_PORT_MEMORY -- requirements
Module: pipelined_dual_port_memory

Interface
REQ-001 SHALL have parameter INIT_FILE, default "", hex image loaded at elaboration; empty string means no load and contents start at zero.
REQ-002 SHALL have parameter CAPACITY_BYTES, default 1024, total bytes; power of two, at least 2*WORD_BYTES.
REQ-003 SHALL have parameter WORD_BYTES, default 4, bytes per word; power of two.
REQ-004 SHALL have parameter READ_LATENCY, default 2, cycles from read acceptance to rsp_valid; range 1..4.
REQ-005 SHALL have parameter RDW_MODE, default READ_FIRST, read-during-write policy; values READ_FIRST or WRITE_FIRST.
REQ-006 SHALL have ports: clk  in  1  single clock for both ports; reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: clear_req  in  1  start a zero-fill; clear_busy  out  1  zero-fill in progress; clear_done  out  1  one-cycle pulse when the zero-fill completes.
REQ-008 SHALL have, per port p in {a,b}: port_p_req_valid  in  1; port_p_req_ready  out  1; port_p_address  in  $clog2(CAPACITY_BYTES)  byte address; port_p_rd_en  in  1; port_p_wr_en  in  WORD_BYTES  byte mask; port_p_wr_data  in  8*WORD_BYTES.
REQ-009 SHALL have, per port p: port_p_rsp_valid  out  1; port_p_rsp_data  out  8*WORD_BYTES.

Function
REQ-010 Request SHALL be accepted on a rising clk edge where req_valid and req_ready are both high.
REQ-011 Word index SHALL be address[MSB:$clog2(WORD_BYTES)]; low address bits SHALL be ignored.
REQ-012 Accepted write SHALL update exactly the bytes whose wr_en bit is set, in the acceptance cycle.
REQ-013 Accepted read (rd_en=1) SHALL produce rsp_valid=1 with data exactly READ_LATENCY cycles later; responses SHALL return in order; no backpressure on responses.
REQ-014 Read pipeline SHALL accept one read per port per cycle (full throughput) for any READ_LATENCY.
REQ-015 rsp_data SHALL hold its last value while rsp_valid=0.
REQ-016 Request with rd_en=0 and wr_en=0 SHALL be accepted as a no-op with no response.
REQ-017 Both ports writing the same word in one cycle: port A SHALL win every byte both enable; bytes enabled by only one port SHALL take that port's data.
REQ-018 Read and write on the same word in one cycle, same or opposite port: READ_FIRST SHALL return pre-write data; WORD_FIRST is not a value; WRITE_FIRST SHALL return post-write data, including the REQ-017 merge.
REQ-019 Clear FSM SHALL have two states, IDLE and CLEAR.
REQ-020 IDLE to CLEAR SHALL occur when clear_req=1; the request is sampled only in IDLE and ignored in CLEAR.
REQ-021 CLEAR SHALL zero one word per cycle from index 0 to WORD_COUNT-1, taking WORD_COUNT cycles.
REQ-022 CLEAR SHALL return to IDLE after the last word and pulse clear_done for exactly one cycle.
REQ-023 req_ready SHALL be 0 on both ports while clear_busy=1, and 1 otherwise.
REQ-024 Reads already in flight at clear start SHALL still complete with their pre-clear data.
REQ-025 clear_busy SHALL be 1 exactly in state CLEAR.

Reset
REQ-026 reset_n=0 SHALL asynchronously force: FSM to IDLE, clear counter to 0, clear_busy=0, clear_done=0, all rsp_valid=0, all rsp_data=0, all pipeline valid bits=0.
REQ-027 Reset SHALL NOT alter memory contents.
REQ-028 Reset during CLEAR SHALL abort the clear, leaving a partially cleared array, with no clear_done pulse.
REQ-029 Reset deassertion SHALL be synchronised outside this block; req_ready SHALL be 1 in the first cycle after release.

Structure
REQ-030 Package memory_pkg SHALL hold the rdw_mode_e enum (READ_FIRST, WRITE_FIRST) and the clear FSM state enum.
REQ-031 The per-port read delay SHALL be one sub-module, read_pipeline, parametrised by latency and data width, carrying valid and data; it is instantiated twice.
REQ-032 The array SHALL remain inferable as true dual-port block RAM, with no reset on the array.

Verification
REQ-033 Scenario: WORD_BYTES=4, READ_LATENCY=3; write A addr 0x10 data 0xDEADBEEF mask 0xF, then read B addr 0x13 -> rsp_valid on B exactly 3 cycles after accept, data 0xDEADBEEF.
REQ-034 Scenario: both ports write word 0x20 in one cycle, A=0x11111111 mask 0x3, B=0x22222222 mask 0x6 -> readback 0x00221111.
REQ-035 Scenario: word 0x40 holds 0xAAAAAAAA; A writes 0x55555555 while B reads 0x40 in the same cycle -> READ_FIRST returns 0xAAAAAAAA, WRITE_FIRST returns 0x55555555.
REQ-036 Scenario: CAPACITY_BYTES=64, clear_req pulse -> clear_busy for 16 cycles, req_ready=0 throughout, one clear_done pulse, all words read 0.
REQ-037 Scenario: assert reset_n=0 at clear word 5 -> clear_busy=0 immediately, no clear_done; words 0-4 read 0 and words from 5 hold prior data.
REQ-038 Scenario: back-to-back reads every cycle on both ports for 32 cycles -> 32 in-order responses per port with no gaps.
